load_store_unit: RTL and testbench
==================================

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have parameter ADDR_W, default 6, data-memory byte-address width.
REQ-002 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port req_valid  input  1  memory-stage request present.
REQ-005 SHALL have port req_ready  output  1  unit accepts request this cycle.
REQ-006 SHALL have port req_is_store  input  1  1=store, 0=load.
REQ-007 SHALL have port req_funct3  input  3  000 b, 001 h, 010 w, 100 bu, 101 hu.
REQ-008 SHALL have port req_addr  input  ADDR_W  byte address.
REQ-009 SHALL have port req_wdata  input  32  store data, right-justified.
REQ-010 SHALL have port req_rd  input  5  load destination register.
REQ-011 SHALL have ports mem_read/mem_write  output  1 each  data-memory strobes.
REQ-012 SHALL have ports mem_choose  output  3, mem_addr  output  ADDR_W, mem_wdata  output  32  data-memory controls.
REQ-013 SHALL have port mem_rdata  input  32  combinational data-memory read data.
REQ-014 SHALL have ports wb_valid  output  1, wb_ready  input  1, wb_data  output  32, wb_rd  output  5  load result handshake.
REQ-015 SHALL have port err  output  1  one-cycle illegal-request pulse.

Function
REQ-016 SHALL implement FSM IDLE, XFER, DONE; req_ready=1 only in IDLE with rst high.
REQ-017 SHALL accept a request on req_valid&&req_ready, latching all req_* fields, moving to XFER.
REQ-018 SHALL classify as aligned: byte; half with addr[0]=0; word with addr[1:0]=00; otherwise misaligned.
REQ-019 Aligned: SHALL spend exactly one XFER cycle driving mem_choose=latched funct3, mem_addr=latched addr.
REQ-020 Misaligned: SHALL spend n XFER cycles (n=2 half, 4 word), cycle i driving mem_addr=addr+i mod 2^ADDR_W, mem_choose=000 for stores, 100 for loads.
REQ-021 Byte order big-endian: byte i of the access is bits [8n-1-8i -: 8] of the n-byte value; misaligned store drives that byte in mem_wdata[7:0].
REQ-022 SHALL assert mem_write (store) or mem_read (load) only during XFER cycles; both 0 elsewhere; mem_wdata=0 for loads.
REQ-023 Loads SHALL capture mem_rdata at the end of each XFER cycle and assemble bytes MSB-first.
REQ-024 Misaligned loads SHALL sign-extend (funct3 001) or zero-extend (101) the assembled halfword; word unchanged.
REQ-025 After last XFER, stores SHALL return to IDLE without wb_valid; loads SHALL enter DONE.
REQ-026 In DONE, wb_valid=1 with wb_data/wb_rd stable until wb_ready=1; that cycle completes and returns to IDLE.
REQ-027 Illegal requests (funct3 011/110/111, or store with 100/101) SHALL be accepted, pulse err for the following cycle, perform no memory access, produce no wb_valid, and return to IDLE.
REQ-028 Latency: accept at cycle T; memory cycles T+1..T+n; load wb_valid first at T+n+1.
REQ-029 Address arithmetic SHALL wrap modulo 2^ADDR_W (word at 62 touches 62,63,0,1).

Reset
REQ-030 On rst low SHALL immediately enter IDLE with req_ready, mem_read, mem_write, wb_valid, err = 0 and mem_choose, mem_addr, mem_wdata, wb_data, wb_rd = 0.
REQ-031 Reset mid-operation SHALL abandon the access; bytes already written remain; no wb_valid or err follows.

Verification
REQ-032 Aligned lw addr 8, memory word 5 -> one cycle mem_read=1 choose=010 addr=8; wb_valid at T+2, wb_data=5.
REQ-033 sw 0xA1B2C3D4 addr 5 -> four mem_write cycles, addr 5..8, wdata[7:0] A1,B2,C3,D4; req_ready low 4 cycles; lw addr 5 returns 0xA1B2C3D4.
REQ-034 Bytes 0x80,0x01 at 3,4: lh addr 3 -> wb_data 0xFFFF8001; lhu addr 3 -> 0x00008001.
REQ-035 lw addr 62 -> byte reads at 62,63,0,1; wb_valid held with wb_ready low 3 cycles, data stable, req_ready 0.
REQ-036 funct3 011 -> err pulse one cycle, no mem strobes, no wb_valid; req_ready back to 1 next cycle.
REQ-037 rst low after 2nd byte of misaligned sw -> mem_write 0 immediately, IDLE, only first two bytes written.

Source files
------------

// File: rtl/load_store_unit.sv
// Memory-stage load/store unit: aligned accesses pass straight through,
// misaligned ones are split into big-endian byte transfers.
module load_store_unit #(
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_is_store,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  input  logic [4:0]        req_rd,
  output logic              mem_read,
  output logic              mem_write,
  output logic [2:0]        mem_choose,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  output logic              wb_valid,
  input  logic              wb_ready,
  output logic [31:0]       wb_data,
  output logic [4:0]        wb_rd,
  output logic              err
);

  typedef enum logic [1:0] {
    IDLE,
    XFER,
    DONE
  } state_t;

  state_t            state;
  logic              st_q;
  logic              mis_q;
  logic [2:0]        f3_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;
  logic [4:0]        rd_q;
  logic [1:0]        idx_q;
  logic [31:0]       acc_q;

  logic        legal;
  logic        mis_in;
  logic        xfer;
  logic [1:0]  last;
  logic [4:0]  sh;
  logic [31:0] wsh;
  logic [31:0] acc_nx;
  logic [31:0] ld_res;

  always_comb begin
    legal = 1'b0;
    unique case (req_funct3)
      3'b000, 3'b001, 3'b010: legal = 1'b1;
      3'b100, 3'b101:         legal = ~req_is_store;
      default:                legal = 1'b0;
    endcase
  end

  assign mis_in =
    (req_funct3[1:0] == 2'b01 && req_addr[0]) ||
    (req_funct3[1:0] == 2'b10 && req_addr[1:0] != 2'b00);

  assign last = mis_q ? (f3_q[1] ? 2'd3 : 2'd1) : 2'd0;

  // byte idx of an n-byte store, most significant first
  assign sh  = f3_q[1] ? {~idx_q, 3'b000}
                       : {1'b0, ~idx_q[0], 3'b000};
  assign wsh = wdata_q >> sh;

  assign acc_nx = mis_q ? {acc_q[23:0], mem_rdata[7:0]}
                        : mem_rdata;

  always_comb begin
    ld_res = acc_nx;
    if (mis_q && !f3_q[1]) begin
      if (f3_q[2]) ld_res = {16'h0, acc_nx[15:0]};
      else         ld_res = {{16{acc_nx[15]}}, acc_nx[15:0]};
    end
  end

  assign xfer       = (state == XFER);
  assign req_ready  = rst && (state == IDLE);
  assign mem_read   = xfer && !st_q;
  assign mem_write  = xfer && st_q;
  assign mem_choose = !xfer ? 3'b000
                    : mis_q ? {~st_q, 2'b00} : f3_q;
  assign mem_addr   = xfer ? addr_q + ADDR_W'(idx_q) : '0;
  assign mem_wdata  = !(xfer && st_q) ? 32'h0
                    : mis_q ? {24'h0, wsh[7:0]} : wdata_q;
  assign wb_valid   = (state == DONE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      st_q    <= 1'b0;
      mis_q   <= 1'b0;
      f3_q    <= 3'b000;
      addr_q  <= '0;
      wdata_q <= 32'h0;
      rd_q    <= 5'h0;
      idx_q   <= 2'd0;
      acc_q   <= 32'h0;
      wb_data <= 32'h0;
      wb_rd   <= 5'h0;
      err     <= 1'b0;
    end else begin
      err <= 1'b0;
      unique case (state)
        IDLE: begin
          if (req_valid) begin
            st_q    <= req_is_store;
            mis_q   <= mis_in;
            f3_q    <= req_funct3;
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
            rd_q    <= req_rd;
            idx_q   <= 2'd0;
            acc_q   <= 32'h0;
            if (legal) state <= XFER;
            else       err   <= 1'b1;
          end
        end
        XFER: begin
          if (!st_q) acc_q <= acc_nx;
          if (idx_q == last) begin
            if (st_q) begin
              state <= IDLE;
            end else begin
              state   <= DONE;
              wb_data <= ld_res;
              wb_rd   <= rd_q;
            end
          end else begin
            idx_q <= idx_q + 2'd1;
          end
        end
        DONE: begin
          if (wb_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: byte-array memory, reference byte model,
// and a load-result scoreboard.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_is_store = 1'b0;
  logic [2:0]  req_funct3 = 3'b000;
  logic [5:0]  req_addr = 6'h0;
  logic [31:0] req_wdata = 32'h0;
  logic [4:0]  req_rd = 5'h0;
  logic        mem_read;
  logic        mem_write;
  logic [2:0]  mem_choose;
  logic [5:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        wb_valid;
  logic        wb_ready = 1'b1;
  logic [31:0] wb_data;
  logic [4:0]  wb_rd;
  logic        err;

  load_store_unit #(.ADDR_W(6)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_is_store(req_is_store), .req_funct3(req_funct3),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_rd(req_rd),
    .mem_read(mem_read), .mem_write(mem_write),
    .mem_choose(mem_choose), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .wb_valid(wb_valid), .wb_ready(wb_ready),
    .wb_data(wb_data), .wb_rd(wb_rd), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] d;
  } wb_t;

  typedef struct {
    logic        wr;
    logic [2:0]  ch;
    logic [5:0]  a;
    logic [31:0] wd;
  } mcyc_t;

  int    n_chk = 0;
  int    n_fail = 0;
  int    err_n = 0;
  wb_t   sbq[$];
  wb_t   sb_e;
  mcyc_t mlog[$];

  logic [7:0] dmem    [64] = '{default: 8'h00};
  logic [7:0] ref_mem [64] = '{default: 8'h00};
  logic [5:0] ma1, ma2, ma3;

  assign ma1 = mem_addr + 6'd1;
  assign ma2 = mem_addr + 6'd2;
  assign ma3 = mem_addr + 6'd3;

  // big-endian byte memory honouring the access size code
  always_comb begin
    mem_rdata = 32'h0;
    case (mem_choose)
      3'b000: mem_rdata = {{24{dmem[mem_addr][7]}}, dmem[mem_addr]};
      3'b100: mem_rdata = {24'h0, dmem[mem_addr]};
      3'b001: mem_rdata = {{16{dmem[mem_addr][7]}}, dmem[mem_addr], dmem[ma1]};
      3'b101: mem_rdata = {16'h0, dmem[mem_addr], dmem[ma1]};
      3'b010: mem_rdata = {dmem[mem_addr], dmem[ma1], dmem[ma2], dmem[ma3]};
      default: mem_rdata = 32'h0;
    endcase
  end

  always @(posedge clk) begin
    if (mem_write) begin
      case (mem_choose)
        3'b000: dmem[mem_addr] <= mem_wdata[7:0];
        3'b001: begin
          dmem[mem_addr] <= mem_wdata[15:8];
          dmem[ma1]      <= mem_wdata[7:0];
        end
        3'b010: begin
          dmem[mem_addr] <= mem_wdata[31:24];
          dmem[ma1]      <= mem_wdata[23:16];
          dmem[ma2]      <= mem_wdata[15:8];
          dmem[ma3]      <= mem_wdata[7:0];
        end
        default: ;
      endcase
    end
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  function automatic bit legal_tb(input logic st, input logic [2:0] f3);
    case (f3)
      3'b000, 3'b001, 3'b010: return 1'b1;
      3'b100, 3'b101:         return !st;
      default:                return 1'b0;
    endcase
  endfunction

  function automatic logic [31:0] ref_ld(input logic [2:0] f3,
                                         input logic [5:0] a);
    logic [5:0]  a1;
    logic [5:0]  a2;
    logic [5:0]  a3;
    logic [7:0]  b0;
    logic [15:0] h;
    a1 = a + 6'd1;
    a2 = a + 6'd2;
    a3 = a + 6'd3;
    b0 = ref_mem[a];
    h  = {ref_mem[a], ref_mem[a1]};
    case (f3)
      3'b000:  return {{24{b0[7]}}, b0};
      3'b100:  return {24'h0, b0};
      3'b001:  return {{16{h[15]}}, h};
      3'b101:  return {16'h0, h};
      default: return {ref_mem[a], ref_mem[a1], ref_mem[a2], ref_mem[a3]};
    endcase
  endfunction

  task automatic ref_st(input logic [2:0] f3, input logic [5:0] a,
                        input logic [31:0] wd);
    int n;
    logic [31:0] s;
    n = (f3 == 3'b000) ? 1 : (f3 == 3'b001) ? 2 : 4;
    for (int i = 0; i < n; i++) begin
      s = wd >> (8 * (n - 1 - i));
      ref_mem[a + 6'(i)] = s[7:0];
    end
  endtask

  // entered and left just after a rising edge
  task automatic issue(input logic st, input logic [2:0] f3,
                       input logic [5:0] a, input logic [31:0] wd,
                       input logic [4:0] rd, input bit upd);
    int t;
    t = 0;
    while (!req_ready && t < 100) begin
      @(posedge clk); #1;
      t++;
    end
    if (!req_ready) chk("rdy_to", {31'h0, req_ready}, 32'h1);
    req_valid    = 1'b1;
    req_is_store = st;
    req_funct3   = f3;
    req_addr     = a;
    req_wdata    = wd;
    req_rd       = rd;
    if (upd && legal_tb(st, f3)) begin
      if (st) ref_st(f3, a, wd);
      else    sbq.push_back('{rd, ref_ld(f3, a)});
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic wait_done();
    int t;
    t = 0;
    while ((sbq.size() != 0 || !req_ready) && t < 100) begin
      @(posedge clk); #1;
      t++;
    end
    if (t >= 100) chk("wait_to", 32'(sbq.size()), 32'h0);
  endtask

  always @(negedge clk) begin
    if (mem_read || mem_write)
      mlog.push_back('{mem_write, mem_choose, mem_addr, mem_wdata});
    if (err) err_n++;
    if (wb_valid && wb_ready) begin
      if (sbq.size() == 0) begin
        chk("wb_unexp", 32'(sbq.size()), 32'h1);
      end else begin
        sb_e = sbq.pop_front();
        chk("wb_data", wb_data, sb_e.d);
        chk("wb_rd", {27'h0, wb_rd}, {27'h0, sb_e.rd});
      end
    end
  end

  initial begin
    int cnt;
    int bad;
    logic [31:0] s;
    logic [31:0] wexp;
    logic [2:0]  f3;
    logic [5:0]  ea [4];

    #12;
    chk("rst_ctl", {27'h0, req_ready, mem_read, mem_write, wb_valid, err}, 32'h0);
    chk("rst_ch", {29'h0, mem_choose}, 32'h0);
    chk("rst_addr", {26'h0, mem_addr}, 32'h0);
    chk("rst_wd", mem_wdata, 32'h0);
    chk("rst_wb", wb_data | {27'h0, wb_rd}, 32'h0);
    #5 rst = 1'b1;
    #1 chk("rdy_post_rst", {31'h0, req_ready}, 32'h1);
    @(posedge clk); #1;

    // aligned word load, latency and single memory cycle
    issue(1'b1, 3'b010, 6'd8, 32'h5, 5'd0, 1'b1);
    wait_done();
    mlog.delete();
    issue(1'b0, 3'b010, 6'd8, 32'h0, 5'd3, 1'b1);
    @(negedge clk);
    chk("lw_lat1", {31'h0, wb_valid}, 32'h0);
    @(negedge clk);
    chk("lw_lat2", {31'h0, wb_valid}, 32'h1);
    wait_done();
    chk("lw_n", 32'(mlog.size()), 32'd1);
    if (mlog.size() > 0)
      chk("lw_cyc", {mlog[0].wr, mlog[0].ch, mlog[0].a, mlog[0].wd[21:0]},
          {1'b0, 3'b010, 6'd8, 22'h0});

    // misaligned word store then load back
    mlog.delete();
    issue(1'b1, 3'b010, 6'd5, 32'hA1B2C3D4, 5'd0, 1'b1);
    cnt = 1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (req_ready) break;
      cnt++;
    end
    chk("sw_busy", 32'(cnt - 1), 32'd4);
    chk("sw_n", 32'(mlog.size()), 32'd4);
    wexp = 32'hA1B2C3D4;
    for (int i = 0; i < 4 && i < mlog.size(); i++) begin
      s = wexp >> (24 - 8 * i);
      chk("sw_a", {26'h0, mlog[i].a}, 32'(5 + i));
      chk("sw_wd", mlog[i].wd, {24'h0, s[7:0]});
      chk("sw_ch", {28'h0, mlog[i].wr, mlog[i].ch}, 32'h8);
    end
    @(posedge clk); #1;
    issue(1'b0, 3'b010, 6'd5, 32'h0, 5'd7, 1'b1);
    wait_done();

    // misaligned half loads, signed and unsigned
    issue(1'b1, 3'b000, 6'd3, 32'h80, 5'd0, 1'b1);
    issue(1'b1, 3'b000, 6'd4, 32'h01, 5'd0, 1'b1);
    issue(1'b0, 3'b001, 6'd3, 32'h0, 5'd5, 1'b1);
    issue(1'b0, 3'b101, 6'd3, 32'h0, 5'd6, 1'b1);
    wait_done();
    chk("lh_model", ref_ld(3'b001, 6'd3), 32'hFFFF8001);

    // wrapping word access with backpressure on the result
    issue(1'b1, 3'b010, 6'd62, 32'h12345678, 5'd0, 1'b1);
    wait_done();
    mlog.delete();
    wb_ready = 1'b0;
    issue(1'b0, 3'b010, 6'd62, 32'h0, 5'd9, 1'b1);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (wb_valid) break;
    end
    for (int i = 0; i < 3; i++) begin
      if (i > 0) @(negedge clk);
      chk("hold_v", {30'h0, wb_valid, req_ready}, 32'h2);
      chk("hold_d", wb_data, 32'h12345678);
    end
    @(posedge clk); #1;
    wb_ready = 1'b1;
    wait_done();
    ea = '{6'd62, 6'd63, 6'd0, 6'd1};
    chk("wrap_n", 32'(mlog.size()), 32'd4);
    for (int i = 0; i < 4 && i < mlog.size(); i++)
      chk("wrap_a", {mlog[i].wr, mlog[i].ch, mlog[i].a},
          {1'b0, 3'b100, ea[i]});

    // illegal requests
    mlog.delete();
    issue(1'b0, 3'b011, 6'd0, 32'h0, 5'd1, 1'b1);
    @(negedge clk);
    chk("ill_err", {30'h0, err, req_ready}, 32'h3);
    @(negedge clk);
    chk("ill_err_end", {31'h0, err}, 32'h0);
    @(posedge clk); #1;
    issue(1'b1, 3'b101, 6'd9, 32'hFFFF, 5'd0, 1'b1);
    @(negedge clk);
    chk("ill_st_err", {31'h0, err}, 32'h1);
    @(posedge clk); #1;
    chk("ill_mem", 32'(mlog.size()), 32'h0);

    // reset in the middle of a misaligned store
    issue(1'b1, 3'b000, 6'd23, 32'hEE, 5'd0, 1'b1);
    issue(1'b1, 3'b000, 6'd24, 32'hEF, 5'd0, 1'b1);
    wait_done();
    issue(1'b1, 3'b010, 6'd21, 32'h11223344, 5'd0, 1'b0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("mid_pre", {31'h0, mem_write}, 32'h1);
    rst = 1'b0;
    #1;
    chk("mid_rst", {26'h0, req_ready, mem_write, mem_addr[3:0]}, 32'h0);
    #2 rst = 1'b1;
    ref_mem[21] = 8'h11;
    ref_mem[22] = 8'h22;
    @(posedge clk); #1;
    chk("mid_mem", {dmem[21], dmem[22], dmem[23], dmem[24]}, 32'h1122EEEF);

    // random mixed traffic
    for (int k = 0; k < 40; k++) begin
      if ($urandom_range(0, 1) == 1) begin
        f3 = 3'($urandom_range(0, 2));
        issue(1'b1, f3, 6'($urandom_range(0, 63)), $urandom, 5'd0, 1'b1);
      end else begin
        cnt = $urandom_range(0, 4);
        f3 = (cnt < 3) ? 3'(cnt) : 3'(cnt + 1);
        issue(1'b0, f3, 6'($urandom_range(0, 63)), 32'h0,
              5'($urandom_range(1, 31)), 1'b1);
      end
    end
    wait_done();

    bad = 0;
    for (int i = 0; i < 64; i++)
      if (dmem[i] !== ref_mem[i]) bad++;
    chk("mem_img", 32'(bad), 32'h0);
    chk("err_n", 32'(err_n), 32'd2);
    chk("sb_left", 32'(sbq.size()), 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_chk, n_fail);
    $finish;
  end

endmodule
